// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit multiplexed seven-segment scan controller.
// Each digit slot lasts CLK_DIV clocks: GAP_CYC clocks with every anode off
// (so the previous digit's segments can settle without ghosting), then the
// remaining clocks with the selected anode on. New display data is staged on
// load and moved into the shadow register only at a frame boundary, so a
// frame never shows a mix of old and new digits.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         scan enable; low forces IDLE on the next edge
//   load       one-cycle request to capture data_in / dp_in
//   data_in    eight 4-bit digits, digit i at [4i+3:4i]
//   dp_in      decimal point per digit, 1 = lit
//   lz_blank   leading-zero blanking enable
//   sel        index of the digit being scanned
//   digit      shadow nibble selected by sel
//   an         anode enables, active-low
//   dp         decimal point, active-low
//   frame_done one-cycle pulse at the end of digit 7's slot
//   load_ack   one-cycle pulse after new data reaches the shadow register
module seg_scan_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int GAP_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        lz_blank,
    output logic [2:0]  sel,
    output logic [3:0]  digit,
    output logic [7:0]  an,
    output logic        dp,
    output logic        frame_done,
    output logic        load_ack
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       sel_n;
    logic [31:0]      shadow, shadow_n, staging, staging_n;
    logic [7:0]       shadow_dp, shadow_dp_n, staging_dp, staging_dp_n;
    logic             pending, pending_n;
    logic [3:0]       digit_n;
    logic [7:0]       an_n;
    logic             dp_n, frame_done_n, load_ack_n;
    logic             wrap;

    // A digit above 0 is blanked when it and every more significant nibble are zero.
    function automatic logic is_blank(input logic [31:0] sh, input logic [2:0] idx,
                                      input logic lz);
        logic zero;
        zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j >= int'(idx) && sh[4*j +: 4] != 4'd0) zero = 1'b0;
        end
        return lz && (idx != 3'd0) && zero;
    endfunction

    // The counter runs 0..CLK_DIV-1 across the whole slot; the first GAP_CYC
    // counts are the gap, so it is reset only on slot entry.
    assign wrap = en && (state == S_ON) && (cnt == SLOT_LAST) && (sel == 3'd7);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        sel_n        = sel;
        frame_done_n = 1'b0;
        if (!en) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            sel_n   = 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                    sel_n   = 3'd0;
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) state_n = S_ON;
                    cnt_n = cnt + CNT_W'(1);
                end
                S_ON: begin
                    if (cnt == SLOT_LAST) begin
                        state_n      = S_GAP;
                        cnt_n        = '0;
                        sel_n        = sel + 3'd1;
                        frame_done_n = (sel == 3'd7);
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    sel_n   = 3'd0;
                end
            endcase
        end
    end

    // Display data: direct to shadow when idle or exactly at the frame
    // boundary (a newer load beats older staged data), otherwise staged.
    always_comb begin
        shadow_n     = shadow;
        shadow_dp_n  = shadow_dp;
        staging_n    = staging;
        staging_dp_n = staging_dp;
        pending_n    = pending;
        load_ack_n   = 1'b0;
        if (load) begin
            if (state == S_IDLE || wrap) begin
                shadow_n    = data_in;
                shadow_dp_n = dp_in;
                pending_n   = 1'b0;
                load_ack_n  = 1'b1;
            end else begin
                staging_n    = data_in;
                staging_dp_n = dp_in;
                pending_n    = 1'b1;
            end
        end else if (wrap && pending) begin
            shadow_n    = staging;
            shadow_dp_n = staging_dp;
            pending_n   = 1'b0;
            load_ack_n  = 1'b1;
        end
    end

    // Output values are computed from next-state values so every output is a
    // plain register that changes on the same edge as sel.
    always_comb begin
        an_n    = 8'hFF;
        dp_n    = 1'b1;
        digit_n = shadow_n[{sel_n, 2'b00} +: 4];
        if (state_n == S_ON) begin
            an_n = is_blank(shadow_n, sel_n, lz_blank) ? 8'hFF : ~(8'd1 << sel_n);
            dp_n = ~shadow_dp_n[sel_n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel        <= 3'd0;
            digit      <= 4'd0;
            an         <= 8'hFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
            shadow     <= '0;
            shadow_dp  <= '0;
            staging    <= '0;
            staging_dp <= '0;
            pending    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            digit      <= digit_n;
            an         <= an_n;
            dp         <= dp_n;
            frame_done <= frame_done_n;
            load_ack   <= load_ack_n;
            shadow     <= shadow_n;
            shadow_dp  <= shadow_dp_n;
            staging    <= staging_n;
            staging_dp <= staging_dp_n;
            pending    <= pending_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with CLK_DIV=8, GAP_CYC=2 (64-cycle frame).
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, load, lz_blank;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [2:0]  sel;
    logic [3:0]  digit;
    logic [7:0]  an;
    logic        dp, frame_done, load_ack;

    seg_scan_ctrl #(.CLK_DIV(8), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
        .dp_in(dp_in), .lz_blank(lz_blank), .sel(sel), .digit(digit),
        .an(an), .dp(dp), .frame_done(frame_done), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [2:0] sel;
        logic [3:0] digit;
        logic       dp;
        logic       fd;
        logic       ack;
    } out_t;

    typedef struct {
        logic       r;
        logic       e;
        logic [7:0] an;
        logic [2:0] sel;
        logic       fd;
    } vec_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;

    // Reference model: position m_t (0..63) inside the frame while scanning.
    bit          m_act;
    int          m_t;
    logic [31:0] m_sh, m_st;
    logic [7:0]  m_sdp, m_stdp;
    logic        m_pend;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_eval(output out_t o);
        bit   was_act, wrap, on, blank;
        int   slot;
        if (rst) begin
            m_act = 0; m_t = 0; m_sh = '0; m_sdp = '0; m_st = '0; m_stdp = '0; m_pend = 0;
            o.an = 8'hFF; o.sel = 3'd0; o.digit = 4'd0; o.dp = 1'b1; o.fd = 1'b0; o.ack = 1'b0;
            return;
        end
        was_act = m_act;
        wrap    = was_act && en && (m_t == 63);
        o.ack   = 1'b0;
        if (load) begin
            if (!was_act || wrap) begin
                m_sh = data_in; m_sdp = dp_in; m_pend = 0; o.ack = 1'b1;
            end else begin
                m_st = data_in; m_stdp = dp_in; m_pend = 1;
            end
        end else if (wrap && m_pend) begin
            m_sh = m_st; m_sdp = m_stdp; m_pend = 0; o.ack = 1'b1;
        end
        if (!en) begin
            m_act = 0; m_t = 0;
        end else if (!was_act) begin
            m_act = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % 64;
        end
        o.fd    = wrap;
        slot    = m_act ? m_t / 8 : 0;
        on      = m_act && (m_t % 8) >= 2;
        blank   = lz_blank && slot >= 1 && (m_sh >> (4 * slot)) == 32'd0;
        o.sel   = 3'(slot);
        o.digit = m_sh[4*slot +: 4];
        o.an    = (on && !blank) ? ~(8'd1 << slot) : 8'hFF;
        o.dp    = on ? ~m_sdp[slot] : 1'b1;
    endtask

    task automatic tick_core(input out_t e);
        out_t x;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("an", an, x.an);
        chk("sel", sel, x.sel);
        chk("digit", digit, x.digit);
        chk("dp", dp, x.dp);
        chk("frame_done", frame_done, x.fd);
        chk("load_ack", load_ack, x.ack);
        ack_cnt += load_ack;
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic tick();
        out_t e;
        model_eval(e);
        tick_core(e);
    endtask

    task automatic run_to(input int target);
        int g = 0;
        while (!(m_act && m_t == target) && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL run_to: position %0d not reached, got=%0d", target, m_t);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    vec_t tab[19];

    initial begin
        int last, cyc, nfd, first, bad, good, dp_lo, dp_wrong;
        bit seen;
        out_t dummy, e;

        tab[0]  = '{1'b1, 1'b0, 8'hFF, 3'd0, 1'b0};
        tab[1]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 1'b0};
        tab[2]  = '{1'b0, 1'b1, 8'hFF, 3'd0, 1'b0};
        tab[3]  = '{1'b0, 1'b1, 8'hFE, 3'd0, 1'b0};
        tab[4]  = '{1'b0, 1'b1, 8'hFE, 3'd0, 1'b0};
        tab[5]  = '{1'b0, 1'b1, 8'hFE, 3'd0, 1'b0};
        tab[6]  = '{1'b0, 1'b1, 8'hFE, 3'd0, 1'b0};
        tab[7]  = '{1'b0, 1'b1, 8'hFE, 3'd0, 1'b0};
        tab[8]  = '{1'b0, 1'b1, 8'hFE, 3'd0, 1'b0};
        tab[9]  = '{1'b0, 1'b1, 8'hFF, 3'd1, 1'b0};
        tab[10] = '{1'b0, 1'b1, 8'hFF, 3'd1, 1'b0};
        tab[11] = '{1'b0, 1'b1, 8'hFD, 3'd1, 1'b0};
        tab[12] = '{1'b0, 1'b1, 8'hFD, 3'd1, 1'b0};
        tab[13] = '{1'b0, 1'b1, 8'hFD, 3'd1, 1'b0};
        tab[14] = '{1'b0, 1'b1, 8'hFD, 3'd1, 1'b0};
        tab[15] = '{1'b0, 1'b1, 8'hFD, 3'd1, 1'b0};
        tab[16] = '{1'b0, 1'b1, 8'hFD, 3'd1, 1'b0};
        tab[17] = '{1'b0, 1'b1, 8'hFF, 3'd2, 1'b0};
        tab[18] = '{1'b0, 1'b1, 8'hFF, 3'd2, 1'b0};

        rst = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0;
        data_in = '0; dp_in = '0;
        m_act = 0; m_t = 0; m_sh = '0; m_st = '0; m_sdp = '0; m_stdp = '0; m_pend = 0;
        @(negedge clk);

        // Reset state and the opening slot sequence from a fixed table.
        for (int i = 0; i < 19; i++) begin
            rst = tab[i].r;
            en  = tab[i].e;
            model_eval(dummy);
            e.an = tab[i].an; e.sel = tab[i].sel; e.digit = 4'd0;
            e.dp = 1'b1; e.fd = tab[i].fd; e.ack = 1'b0;
            tick_core(e);
        end

        // Frame period: frame_done every 64 cycles, first one 65 edges after enable.
        en = 1'b1;
        do_reset();
        last = -1; cyc = 0; nfd = 0; first = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (frame_done) begin
                if (last >= 0) chk("fd_interval", cyc - last, 64);
                else first = cyc;
                last = cyc;
                nfd++;
            end
        end
        chk("fd_count", nfd, 3);
        chk("fd_first", first, 65);

        // Mid-frame load with leading-zero blanking.
        do_reset();
        lz_blank = 1'b1;
        run_to(20);
        ack_cnt = 0;
        load = 1'b1; data_in = 32'h0000_0120; dp_in = 8'h00;
        tick();
        bad = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (frame_done) seen = 1;
            else if (sel != 3'd0 && an != 8'hFF) bad++;
        end
        chk("lz_boundary_seen", seen, 1);
        chk("lz_old_frame_blank", bad, 0);
        bad = 0; good = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (sel >= 3'd3 && an != 8'hFF) bad++;
            if (sel <= 3'd2 && an == ~(8'd1 << sel)) good++;
        end
        chk("lz_upper_blank", bad, 0);
        chk("lz_lower_lit", good, 18);
        chk("lz_ack_count", ack_cnt, 1);
        lz_blank = 1'b0;

        // Two loads in one frame: latest wins, single acknowledge.
        do_reset();
        run_to(10);
        ack_cnt = 0;
        load = 1'b1; data_in = 32'h1111_1111;
        tick();
        run_to(30);
        load = 1'b1; data_in = 32'h2222_2222;
        tick();
        run_to(63);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (digit != 4'd2) bad++;
        end
        chk("latest_wins", bad, 0);
        chk("double_load_ack", ack_cnt, 1);

        // Decimal point on digit 7 only, during its ON phase.
        en = 1'b0;
        do_reset();
        load = 1'b1; data_in = 32'h0; dp_in = 8'h80;
        tick();
        en = 1'b1;
        dp_lo = 0; dp_wrong = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (!dp) begin
                dp_lo++;
                if (sel != 3'd7) dp_wrong++;
            end
        end
        chk("dp_low_cycles", dp_lo, 6);
        chk("dp_wrong_slot", dp_wrong, 0);

        // Disable mid-slot, then restart from slot 0.
        do_reset();
        run_to(3 * 8 + 4);
        en = 1'b0;
        tick();
        chk("dis_an", an, 8'hFF);
        chk("dis_sel", sel, 0);
        en = 1'b1;
        tick(); tick(); tick();
        chk("restart_an", an, 8'hFE);

        // Reset during slot 5 ON with data pending: pending is dropped.
        do_reset();
        run_to(10);
        load = 1'b1; data_in = 32'h0000_0005;
        tick();
        run_to(5 * 8 + 3);
        rst = 1'b1;
        tick();
        chk("rst_an", an, 8'hFF);
        chk("rst_sel", sel, 0);
        chk("rst_dp", dp, 1);
        ack_cnt = 0;
        for (int i = 0; i < 70; i++) tick();
        chk("rst_no_ack", ack_cnt, 0);

        // Idle load goes straight through; load on the boundary beats staged data.
        en = 1'b0;
        do_reset();
        load = 1'b1; data_in = 32'h8765_4321; dp_in = 8'h0F;
        tick();
        chk("idle_ack", load_ack, 1);
        chk("idle_digit", digit, 4'h1);
        en = 1'b1;
        run_to(20);
        load = 1'b1; data_in = 32'hAAAA_AAAA;
        tick();
        run_to(63);
        load = 1'b1; data_in = 32'h3333_3333; dp_in = 8'h00;
        tick();
        chk("bnd_fd", frame_done, 1);
        chk("bnd_ack", load_ack, 1);
        chk("bnd_digit", digit, 4'h3);
        for (int i = 0; i < 64; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
